// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: byte-serial instruction memory port, decode handshake
// and the next-PC return path from the PC-update stage.
interface fetch_unit_if;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic [7:0]  imem_rdata;
    logic        imem_ack;
    logic        imem_err;

    logic        out_valid;
    logic        out_ready;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  rA;
    logic [3:0]  rB;
    logic [63:0] valC;
    logic [63:0] valP;
    logic [2:0]  stat;

    logic        pc_valid;
    logic [63:0] pc_next;
    logic [63:0] pc;

    modport master (
        output imem_req, imem_addr,
        input  imem_rdata, imem_ack, imem_err,
        output out_valid,
        input  out_ready,
        output icode, ifun, rA, rB, valC, valP, stat,
        input  pc_valid, pc_next,
        output pc
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_rdata, imem_ack, imem_err,
        input  out_valid,
        output out_ready,
        input  icode, ifun, rA, rB, valC, valP, stat,
        output pc_valid, pc_next,
        input  pc
    );
endinterface

// File: rtl/fetch_unit.sv
// Y86-64 SEQ fetch stage: fetches one instruction byte-serially, presents the decoded
// fields on a valid/ready handshake, then waits for the next PC.
module fetch_unit #(
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter int unsigned IMEM_SIZE = 4096
) (
    input logic         clk,
    input logic         rst,
    fetch_unit_if.master bus
);
    localparam logic [2:0] StatAok = 3'd1;
    localparam logic [2:0] StatHlt = 3'd2;
    localparam logic [2:0] StatAdr = 3'd3;
    localparam logic [2:0] StatIns = 3'd4;

    typedef enum logic [1:0] {StFetch, StOut, StWaitPc, StHalt} state_e;

    state_e      state_q;
    logic [63:0] pc_q, addr_q, valc_q, valp_q;
    logic [3:0]  k_q, len_q, icode_q, ifun_q, ra_q, rb_q;
    logic [2:0]  stat_q;
    logic        req_q, valid_q;

    logic [63:0] fetch_addr;
    logic        addr_ok;
    logic [3:0]  len_dec;
    logic [2:0]  vidx;
    logic        last_byte;

    assign fetch_addr = pc_q + {60'b0, k_q};
    assign addr_ok    = fetch_addr < 64'(IMEM_SIZE);
    assign last_byte  = k_q == len_q - 4'd1;
    // valC byte index: bytes 1..8 for 9-byte forms, 2..9 for 10-byte forms (mod 8 wraps 9 -> 7)
    assign vidx = (len_q == 4'd9) ? k_q[2:0] - 3'd1 : k_q[2:0] - 3'd2;

    always_comb begin
        case (bus.imem_rdata[7:4])
            4'h0, 4'h1, 4'h9:       len_dec = 4'd1;
            4'h2, 4'h6, 4'hA, 4'hB: len_dec = 4'd2;
            4'h7, 4'h8:             len_dec = 4'd9;
            4'h3, 4'h4, 4'h5:       len_dec = 4'd10;
            default:                len_dec = 4'd0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StFetch;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
            k_q     <= 4'd0;
            len_q   <= 4'd0;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
            icode_q <= 4'h0;
            ifun_q  <= 4'h0;
            ra_q    <= 4'hF;
            rb_q    <= 4'hF;
            valc_q  <= 64'h0;
            valp_q  <= 64'h0;
            stat_q  <= StatAok;
        end else begin
            unique case (state_q)
                StFetch: begin
                    if (!req_q) begin
                        if (addr_ok) begin
                            req_q  <= 1'b1;
                            addr_q <= fetch_addr;
                        end else begin
                            stat_q  <= StatAdr;
                            valid_q <= 1'b1;
                            state_q <= StOut;
                        end
                    end else if (bus.imem_ack) begin
                        req_q <= 1'b0;
                        if (bus.imem_err) begin
                            stat_q  <= StatAdr;
                            valid_q <= 1'b1;
                            state_q <= StOut;
                        end else if (k_q == 4'd0) begin
                            icode_q <= bus.imem_rdata[7:4];
                            ifun_q  <= bus.imem_rdata[3:0];
                            len_q   <= len_dec;
                            if (len_dec == 4'd0) begin
                                stat_q  <= StatIns;
                                valid_q <= 1'b1;
                                state_q <= StOut;
                            end else if (len_dec == 4'd1) begin
                                valp_q  <= pc_q + 64'd1;
                                stat_q  <= (bus.imem_rdata[7:4] == 4'h0) ? StatHlt : StatAok;
                                valid_q <= 1'b1;
                                state_q <= StOut;
                            end else begin
                                k_q <= 4'd1;
                            end
                        end else begin
                            if (k_q == 4'd1 && len_q != 4'd9) begin
                                ra_q <= bus.imem_rdata[7:4];
                                rb_q <= bus.imem_rdata[3:0];
                            end else begin
                                valc_q[{vidx, 3'b000} +: 8] <= bus.imem_rdata;
                            end
                            if (last_byte) begin
                                valp_q  <= pc_q + {60'b0, len_q};
                                stat_q  <= StatAok;
                                valid_q <= 1'b1;
                                state_q <= StOut;
                            end else begin
                                k_q <= k_q + 4'd1;
                            end
                        end
                    end
                end
                StOut: begin
                    if (bus.out_ready) begin
                        valid_q <= 1'b0;
                        state_q <= (stat_q == StatAok) ? StWaitPc : StHalt;
                    end
                end
                StWaitPc: begin
                    if (bus.pc_valid) begin
                        pc_q    <= bus.pc_next;
                        k_q     <= 4'd0;
                        ra_q    <= 4'hF;
                        rb_q    <= 4'hF;
                        valc_q  <= 64'h0;
                        state_q <= StFetch;
                    end
                end
                StHalt: begin
                end
                default: state_q <= StHalt;
            endcase
        end
    end

    assign bus.imem_req  = req_q;
    assign bus.imem_addr = addr_q;
    assign bus.out_valid = valid_q;
    assign bus.icode     = icode_q;
    assign bus.ifun      = ifun_q;
    assign bus.rA        = ra_q;
    assign bus.rB        = rb_q;
    assign bus.valC      = valc_q;
    assign bus.valP      = valp_q;
    assign bus.stat      = stat_q;
    assign bus.pc        = pc_q;
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: table of instructions plus hand sequences for stall, halt,
// address/instruction errors and reset mid-fetch; outputs checked through a scoreboard.
module tb_fetch_unit;
    localparam int unsigned IMEM_SIZE = 4096;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fetch_unit_if bus();

    fetch_unit #(.RESET_PC(64'h0), .IMEM_SIZE(IMEM_SIZE)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [63:0]     pc;
        logic [0:9][7:0] bytes;
        int              len;
        logic [3:0]      icode, ifun, ra, rb;
        logic [63:0]     valc, valp;
        logic [2:0]      stat;
    } vec_t;

    typedef struct {
        logic [3:0]  icode, ifun, ra, rb;
        logic [63:0] valc, valp;
        logic [2:0]  stat;
        bit          chk_fld;
        bit          chk_valp;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    vec_t vt[12];

    int checks = 0;
    int errors = 0;

    logic [7:0]  mem [IMEM_SIZE];
    int          ack_delay = 0;
    int          dly = 0;
    int          issue_count = 0;
    int          ack_count = 0;
    int          bad_req = 0;
    logic        req_prev = 1'b0;
    logic [63:0] last_addr = 64'h0;
    bit          err_en = 1'b0;
    logic [63:0] err_addr = 64'h0;

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, act, req);
        end
    endtask

    // Instruction memory responder; ack after ack_delay idle cycles of a held request.
    initial begin
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = 8'h0;
        bus.imem_err   = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.imem_req && !req_prev) issue_count++;
            if (bus.imem_req && bus.imem_addr >= 64'(IMEM_SIZE)) bad_req++;
            if (bus.imem_req && !bus.imem_ack) begin
                if (dly >= ack_delay) begin
                    bus.imem_ack   = 1'b1;
                    bus.imem_rdata = (bus.imem_addr < 64'(IMEM_SIZE)) ?
                                     mem[int'(bus.imem_addr)] : 8'h00;
                    bus.imem_err   = err_en && (bus.imem_addr == err_addr);
                    last_addr      = bus.imem_addr;
                    ack_count++;
                    dly = 0;
                end else begin
                    dly++;
                end
            end else begin
                bus.imem_ack = 1'b0;
                bus.imem_err = 1'b0;
                if (!bus.imem_req) dly = 0;
            end
            req_prev = bus.imem_req;
        end
    end

    // Scoreboard consumer: compare on every accepted output.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got icode %0h, want no output", bus.icode);
                end else begin
                    mon_e = exp_q.pop_front();
                    check64("stat", 64'(bus.stat), 64'(mon_e.stat));
                    if (mon_e.chk_fld) begin
                        check64("icode", 64'(bus.icode), 64'(mon_e.icode));
                        check64("ifun", 64'(bus.ifun), 64'(mon_e.ifun));
                        check64("rA", 64'(bus.rA), 64'(mon_e.ra));
                        check64("rB", 64'(bus.rB), 64'(mon_e.rb));
                        check64("valC", bus.valC, mon_e.valc);
                    end
                    if (mon_e.chk_valp) check64("valP", bus.valP, mon_e.valp);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish, want finish");
        $fatal(1);
    end

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic start_at(input logic [63:0] pc);
        bus.pc_next  = pc;
        bus.pc_valid = 1'b1;
        @(posedge clk);
        #1 bus.pc_valid = 1'b0;
    endtask

    task automatic wait_valid(input int limit, output int cyc);
        cyc = 0;
        while (!bus.out_valid && cyc < limit) begin
            @(posedge clk);
            #1 cyc++;
        end
        if (!bus.out_valid) begin
            checks++;
            errors++;
            $display("FAIL out_valid_timeout: got no out_valid, want out_valid within %0d", limit);
        end
    endtask

    task automatic finish_handshake();
        @(posedge clk);
        #1 check64("out_valid_drop", 64'(bus.out_valid), 64'h0);
    endtask

    task automatic halt_quiet(input string name);
        int n = 0;
        repeat (10) begin
            @(posedge clk);
            #1 if (bus.imem_req || bus.out_valid) n++;
        end
        check64(name, 64'(n), 64'h0);
    endtask

    task automatic check_reset_vals();
        check64("rst_req", 64'(bus.imem_req), 64'h0);
        check64("rst_addr", bus.imem_addr, 64'h0);
        check64("rst_valid", 64'(bus.out_valid), 64'h0);
        check64("rst_icode", 64'(bus.icode), 64'h0);
        check64("rst_ifun", 64'(bus.ifun), 64'h0);
        check64("rst_rA", 64'(bus.rA), 64'hF);
        check64("rst_rB", 64'(bus.rB), 64'hF);
        check64("rst_valC", bus.valC, 64'h0);
        check64("rst_valP", bus.valP, 64'h0);
        check64("rst_stat", 64'(bus.stat), 64'h1);
        check64("rst_pc", bus.pc, 64'h0);
    endtask

    task automatic load(input logic [63:0] pc, input logic [0:9][7:0] b);
        for (int i = 0; i < 10; i++) mem[int'(pc) + i] = b[i];
    endtask

    task automatic run_vec(input vec_t v, input bit first);
        int cyc;
        int a0;
        load(v.pc, v.bytes);
        exp_q.push_back('{v.icode, v.ifun, v.ra, v.rb, v.valc, v.valp, v.stat, 1'b1, 1'b1});
        a0 = ack_count;
        if (first) do_reset();
        else start_at(v.pc);
        wait_valid(60, cyc);
        check64("latency", 64'(cyc), 64'(2 * v.len));
        check64("req_count", 64'(ack_count - a0), 64'(v.len));
        check64("last_addr", last_addr, v.pc + 64'(v.len - 1));
        finish_handshake();
    endtask

    initial begin
        int cyc;
        int a0;
        int i0;
        int n;
        for (int i = 0; i < int'(IMEM_SIZE); i++) mem[i] = 8'h00;
        rst           = 1'b1;
        bus.out_ready = 1'b1;
        bus.pc_valid  = 1'b0;
        bus.pc_next   = 64'h0;
        repeat (2) @(posedge clk);
        #1 check_reset_vals();

        vt[0]  = '{64'h00, 80'h10_00_0000000000000000, 1,  4'h1, 4'h0, 4'hF, 4'hF,
                   64'h0, 64'h01, 3'd1};
        vt[1]  = '{64'h20, 80'h30_F3_EFCDAB8967452301, 10, 4'h3, 4'h0, 4'hF, 4'h3,
                   64'h0123456789ABCDEF, 64'h2A, 3'd1};
        vt[2]  = '{64'h40, 80'h20_12_0000000000000000, 2,  4'h2, 4'h0, 4'h1, 4'h2,
                   64'h0, 64'h42, 3'd1};
        vt[3]  = '{64'h50, 80'h63_AB_0000000000000000, 2,  4'h6, 4'h3, 4'hA, 4'hB,
                   64'h0, 64'h52, 3'd1};
        vt[4]  = '{64'h60, 80'h73_1122334455667788_00, 9,  4'h7, 4'h3, 4'hF, 4'hF,
                   64'h8877665544332211, 64'h69, 3'd1};
        vt[5]  = '{64'h70, 80'h80_0001000000000000_00, 9,  4'h8, 4'h0, 4'hF, 4'hF,
                   64'h100, 64'h79, 3'd1};
        vt[6]  = '{64'h80, 80'h90_00_0000000000000000, 1,  4'h9, 4'h0, 4'hF, 4'hF,
                   64'h0, 64'h81, 3'd1};
        vt[7]  = '{64'h90, 80'hA0_4F_0000000000000000, 2,  4'hA, 4'h0, 4'h4, 4'hF,
                   64'h0, 64'h92, 3'd1};
        vt[8]  = '{64'hA0, 80'h50_12_0800000000000000, 10, 4'h5, 4'h0, 4'h1, 4'h2,
                   64'h8, 64'hAA, 3'd1};
        vt[9]  = '{64'hB0, 80'h23_41_0000000000000000, 2,  4'h2, 4'h3, 4'h4, 4'h1,
                   64'h0, 64'hB2, 3'd1};
        vt[10] = '{64'hC0, 80'hB0_5F_0000000000000000, 2,  4'hB, 4'h0, 4'h5, 4'hF,
                   64'h0, 64'hC2, 3'd1};
        vt[11] = '{64'hD0, 80'h40_37_F0DEBC9A78563412, 10, 4'h4, 4'h0, 4'h3, 4'h7,
                   64'h123456789ABCDEF0, 64'hDA, 3'd1};

        for (int i = 0; i < 12; i++) run_vec(vt[i], i == 0);

        // Stall in OUT with pc_valid pulsed, then halt.
        mem[256] = 8'h00;
        exp_q.push_back('{4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'h101, 3'd2, 1'b1, 1'b1});
        bus.out_ready = 1'b0;
        start_at(64'h100);
        wait_valid(20, cyc);
        for (int i = 0; i < 5; i++) begin
            bus.pc_valid = 1'b1;
            bus.pc_next  = 64'h500;
            @(posedge clk);
            #1 check64("stall_valid", 64'(bus.out_valid), 64'h1);
            check64("stall_valP", bus.valP, 64'h101);
            check64("stall_pc", bus.pc, 64'h100);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.pc_valid = 1'b0;
        check64("halt_valid", 64'(bus.out_valid), 64'h0);
        check64("halt_pc", bus.pc, 64'h100);
        halt_quiet("halt_quiet");
        check64("halt_stat", 64'(bus.stat), 64'h2);

        // Invalid instruction byte.
        mem[0] = 8'hC0;
        exp_q.push_back('{4'hC, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0, 3'd4, 1'b1, 1'b0});
        a0 = ack_count;
        do_reset();
        wait_valid(20, cyc);
        check64("ins_req_count", 64'(ack_count - a0), 64'h1);
        finish_handshake();
        halt_quiet("ins_quiet");

        // call running off the end of instruction memory.
        mem[0] = 8'h10;
        exp_q.push_back('{4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h1, 3'd1, 1'b1, 1'b1});
        do_reset();
        wait_valid(20, cyc);
        finish_handshake();
        mem[4092] = 8'h80;
        mem[4093] = 8'h11;
        mem[4094] = 8'h22;
        mem[4095] = 8'h33;
        exp_q.push_back('{4'h8, 4'h0, 4'hF, 4'hF, 64'h332211, 64'h0, 3'd3, 1'b1, 1'b0});
        a0 = ack_count;
        n  = bad_req;
        start_at(64'(IMEM_SIZE - 4));
        wait_valid(40, cyc);
        check64("adr_req_count", 64'(ack_count - a0), 64'h4);
        check64("adr_no_oob_req", 64'(bad_req - n), 64'h0);
        finish_handshake();
        halt_quiet("adr_quiet");

        // Memory fault on byte 0.
        err_en   = 1'b1;
        err_addr = 64'h0;
        exp_q.push_back('{4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0, 3'd3, 1'b0, 1'b0});
        do_reset();
        wait_valid(20, cyc);
        finish_handshake();
        err_en = 1'b0;
        halt_quiet("err_quiet");

        // Reset while byte 4 of a jmp is outstanding, then refetch.
        load(64'h0, 80'h70_EFBEADDE00000000_00);
        ack_delay = 3;
        i0 = issue_count;
        do_reset();
        n = 0;
        while (issue_count - i0 < 5 && n < 200) begin
            @(posedge clk);
            #1 n++;
        end
        check64("mid_outstanding", 64'(bus.imem_req), 64'h1);
        check64("mid_addr", bus.imem_addr, 64'h4);
        rst = 1'b1;
        #1 check_reset_vals();
        ack_delay = 0;
        exp_q.push_back('{4'h7, 4'h0, 4'hF, 4'hF, 64'hDEADBEEF, 64'h9, 3'd1, 1'b1, 1'b1});
        @(posedge clk);
        a0 = ack_count;
        #1 rst = 1'b0;
        wait_valid(40, cyc);
        check64("refetch_latency", 64'(cyc), 64'd18);
        check64("refetch_req_count", 64'(ack_count - a0), 64'd9);
        finish_handshake();

        check64("sb_empty", 64'(exp_q.size()), 64'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
